// File: rtl/blockade_video_pkg.sv
// rtl/blockade_video_pkg.sv - shared constants, colour type and overlay palette for the video shifter
package blockade_video_pkg;

  localparam logic [2:0] LOAD_PHASE_DEF = 3'd7;
  localparam int         SYNC_DELAY_DEF = 9;

  typedef logic [2:0] rgb_t;

  // Gel overlay colour per 32-line band: cyan at top, green middle, yellow bottom.
  localparam rgb_t OVERLAY_LUT [8] = '{
    3'b011, 3'b011,
    3'b010, 3'b010, 3'b010, 3'b010,
    3'b110, 3'b110
  };

endpackage

// File: rtl/blockade_video_if.sv
// rtl/blockade_video_if.sv - timing/PROM inputs and video outputs of the pixel output stage
interface blockade_video_if;

  logic       ce_pix;
  logic [8:0] h_count;
  logic [8:0] v_count;
  logic       hsync_in;
  logic       vsync_in;
  logic       hblank_in;
  logic       vblank_in;
  logic [7:0] prom_data;
  logic       r;
  logic       g;
  logic       b;
  logic       hsync;
  logic       vsync;
  logic       hblank;
  logic       vblank;
  logic       load_stb;

  modport master (
    output ce_pix, h_count, v_count, hsync_in, vsync_in, hblank_in, vblank_in, prom_data,
    input  r, g, b, hsync, vsync, hblank, vblank, load_stb
  );

  modport slave (
    input  ce_pix, h_count, v_count, hsync_in, vsync_in, hblank_in, vblank_in, prom_data,
    output r, g, b, hsync, vsync, hblank, vblank, load_stb
  );

endinterface

// File: rtl/blockade_delay_line.sv
// rtl/blockade_delay_line.sv - DEPTH-stage shift line advanced on ce, every stage resets to RESET_VAL
module blockade_delay_line #(
  parameter int                WIDTH     = 1,
  parameter int                DEPTH     = 9,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= RESET_VAL;
      end
    end else if (ce) begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/blockade_video_shifter.sv
// rtl/blockade_video_shifter.sv - serialises PROM row bytes MSB-first and aligns syncs/blanks to them
// Optional colour gel overlay selected by BLOCKADE_COLOR_OVERLAY_EN (monochrome white when undefined).
module blockade_video_shifter
  import blockade_video_pkg::*;
#(
  parameter logic [2:0] LOAD_PHASE = LOAD_PHASE_DEF,
  parameter int         SYNC_DELAY = SYNC_DELAY_DEF,
  parameter logic       INVERT     = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  blockade_video_if.slave vid
);

  logic [7:0] shifter;
  logic       load_stb_q;
  logic       load_hit;
  logic       pixel;
  logic [3:0] sync_d;
  logic       blank_any;
  rgb_t       pix_color;
  rgb_t       rgb;

  assign load_hit = vid.ce_pix && (vid.h_count[2:0] == LOAD_PHASE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      shifter    <= 8'h00;
      load_stb_q <= 1'b0;
    end else begin
      load_stb_q <= load_hit;
      if (load_hit) begin
        shifter <= vid.prom_data;
      end else if (vid.ce_pix) begin
        shifter <= {shifter[6:0], 1'b0};
      end
    end
  end

  assign pixel = shifter[7] ^ INVERT;

  // Bundle order {hsync, vsync, hblank, vblank}; blanks idle high, syncs idle low.
  blockade_delay_line #(
    .WIDTH     (4),
    .DEPTH     (SYNC_DELAY),
    .RESET_VAL (4'b0011)
  ) u_sync_dl (
    .clk   (clk),
    .reset (reset),
    .ce    (vid.ce_pix),
    .d     ({vid.hsync_in, vid.vsync_in, vid.hblank_in, vid.vblank_in}),
    .q     (sync_d)
  );

  assign blank_any = sync_d[1] | sync_d[0];

`ifdef BLOCKADE_COLOR_OVERLAY_EN
  logic [2:0] band_d;
  logic       unused_inputs;

  blockade_delay_line #(
    .WIDTH     (3),
    .DEPTH     (SYNC_DELAY),
    .RESET_VAL (3'b000)
  ) u_band_dl (
    .clk   (clk),
    .reset (reset),
    .ce    (vid.ce_pix),
    .d     (vid.v_count[7:5]),
    .q     (band_d)
  );

  assign pix_color     = OVERLAY_LUT[band_d];
  assign unused_inputs = &{1'b0, vid.h_count[8:3], vid.v_count[8], vid.v_count[4:0]};
`else
  logic unused_inputs;

  assign pix_color     = 3'b111;
  assign unused_inputs = &{1'b0, vid.h_count[8:3], vid.v_count};
`endif

  assign rgb = (blank_any || !pixel) ? 3'b000 : pix_color;

  assign vid.r        = rgb[2];
  assign vid.g        = rgb[1];
  assign vid.b        = rgb[0];
  assign vid.hsync    = sync_d[3];
  assign vid.vsync    = sync_d[2];
  assign vid.hblank   = sync_d[1];
  assign vid.vblank   = sync_d[0];
  assign vid.load_stb = load_stb_q;

endmodule

// File: tb/tb_blockade_video_shifter.sv
// tb/tb_blockade_video_shifter.sv - directed-vector bench for blockade_video_shifter
module tb_blockade_video_shifter;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_bad;

  blockade_video_if vif ();

  blockade_video_shifter dut (
    .clk   (clk),
    .reset (reset),
    .vid   (vif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected colour of a lit pixel for a given vertical count.
  function automatic logic [2:0] exp_col(input logic [8:0] v);
`ifdef BLOCKADE_COLOR_OVERLAY_EN
    case (v[7:5])
      3'd0, 3'd1:             return 3'b011;
      3'd2, 3'd3, 3'd4, 3'd5: return 3'b010;
      default:                return 3'b110;
    endcase
`else
    return 3'b111;
`endif
  endfunction

  task automatic tick();
    vif.ce_pix = 1'b1;
    @(posedge clk);
    #1;
    vif.ce_pix = 1'b0;
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) begin
      vif.h_count = 9'd1;
      tick();
    end
  endtask

  // Load at h=7 then seven shift ticks; pixel k is the output visible after the k-th edge.
  task automatic run_cell(input logic [7:0] data, input int gap,
                          output logic [7:0] rb, output logic [7:0] gb, output logic [7:0] bb,
                          output int loads, output int diffs);
    logic [6:0] snap;
    loads = 0;
    diffs = 0;
    for (int k = 0; k < 8; k++) begin
      vif.h_count   = (k == 0) ? 9'd7 : 9'(k - 1);
      vif.prom_data = (k == 0) ? data : 8'h5A;
      tick();
      rb[7-k] = vif.r;
      gb[7-k] = vif.g;
      bb[7-k] = vif.b;
      if (vif.load_stb) loads++;
      snap = {vif.r, vif.g, vif.b, vif.hsync, vif.vsync, vif.hblank, vif.vblank};
      for (int c = 0; c < gap; c++) begin
        @(posedge clk);
        #1;
        if ({vif.r, vif.g, vif.b, vif.hsync, vif.vsync, vif.hblank, vif.vblank} !== snap) diffs++;
      end
    end
  endtask

  logic [7:0]  rb, gb, bb;
  int          loads, diffs;
  logic [11:0] obs;
  logic [2:0]  col;
  logic [7:0]  pats [3];

  initial begin
    n_chk = 0;
    n_bad = 0;
    pats[0] = 8'hA5;
    pats[1] = 8'h3C;
    pats[2] = 8'h81;
    reset         = 1'b0;
    vif.ce_pix    = 1'b0;
    vif.h_count   = 9'd7;
    vif.v_count   = 9'd0;
    vif.hsync_in  = 1'b1;
    vif.vsync_in  = 1'b1;
    vif.hblank_in = 1'b0;
    vif.vblank_in = 1'b0;
    vif.prom_data = 8'hFF;

    // Reset held with ce_pix toggling and a load phase present: reset wins.
    for (int i = 0; i < 5; i++) begin
      tick();
      @(posedge clk);
      #1;
    end
    chk("rst_rgb", {vif.r, vif.g, vif.b}, 3'b000);
    chk("rst_hsync", vif.hsync, 1'b0);
    chk("rst_vsync", vif.vsync, 1'b0);
    chk("rst_hblank", vif.hblank, 1'b1);
    chk("rst_vblank", vif.vblank, 1'b1);
    chk("rst_load_stb", vif.load_stb, 1'b0);

    reset        = 1'b1;
    vif.hsync_in = 1'b0;
    vif.vsync_in = 1'b0;
    flush(10);

    foreach (pats[p]) begin
      col = exp_col(vif.v_count);
      run_cell(pats[p], 0, rb, gb, bb, loads, diffs);
      chk($sformatf("ser_r_%0h", pats[p]), rb, {8{col[2]}} & pats[p]);
      chk($sformatf("ser_g_%0h", pats[p]), gb, {8{col[1]}} & pats[p]);
      chk($sformatf("ser_b_%0h", pats[p]), bb, {8{col[0]}} & pats[p]);
      chk($sformatf("ser_loads_%0h", pats[p]), loads, 1);
    end

    // Single-tick hsync_in: seen after the 9th edge only (visible during tick T+9).
    obs = '0;
    for (int j = 0; j < 12; j++) begin
      vif.h_count  = 9'd1;
      vif.hsync_in = (j == 0);
      tick();
      obs[j] = vif.hsync;
    end
    chk("hsync_align", obs, 12'h100);

    obs = '0;
    for (int j = 0; j < 12; j++) begin
      vif.h_count   = (j == 0) ? 9'd255 : 9'd256;
      vif.hblank_in = 1'b1;
      tick();
      obs[j] = vif.hblank;
    end
    chk("hblank_edge", obs, 12'hF00);
    vif.hblank_in = 1'b0;
    flush(10);

    // vblank masks a full-on cell, but the load still happens.
    vif.vblank_in = 1'b1;
    flush(10);
    run_cell(8'hFF, 0, rb, gb, bb, loads, diffs);
    chk("blank_rgb", {rb, gb, bb}, 24'h000000);
    chk("blank_loads", loads, 1);
    chk("blank_vblank_out", vif.vblank, 1'b1);
    vif.vblank_in = 1'b0;
    flush(10);

    // Seven idle clks between every tick.
    col = exp_col(vif.v_count);
    run_cell(8'hA5, 7, rb, gb, bb, loads, diffs);
    chk("gap_r", rb, {8{col[2]}} & 8'hA5);
    chk("gap_g", gb, {8{col[1]}} & 8'hA5);
    chk("gap_b", bb, {8{col[0]}} & 8'hA5);
    chk("gap_loads", loads, 1);
    chk("gap_hold", diffs, 0);

    vif.v_count = 9'h020;
    flush(10);
    run_cell(8'h80, 0, rb, gb, bb, loads, diffs);
`ifdef BLOCKADE_COLOR_OVERLAY_EN
    chk("color_v20", {rb[7], gb[7], bb[7]}, 3'b011);
`else
    chk("color_v20", {rb[7], gb[7], bb[7]}, 3'b111);
`endif
    vif.v_count = 9'h0E0;
    flush(10);
    run_cell(8'h80, 0, rb, gb, bb, loads, diffs);
`ifdef BLOCKADE_COLOR_OVERLAY_EN
    chk("color_vE0", {rb[7], gb[7], bb[7]}, 3'b110);
`else
    chk("color_vE0", {rb[7], gb[7], bb[7]}, 3'b111);
`endif

    // Reset mid-line while a lit pixel is showing.
    vif.v_count = 9'h040;
    flush(10);
    vif.h_count   = 9'd7;
    vif.prom_data = 8'hFF;
    tick();
    chk("mid_pre_g", vif.g, 1'b1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_rgb", {vif.r, vif.g, vif.b}, 3'b000);
    chk("mid_rst_hblank", vif.hblank, 1'b1);
    chk("mid_rst_load_stb", vif.load_stb, 1'b0);
    reset = 1'b1;
    vif.h_count = 9'd0;
    tick();
    chk("mid_post_rgb", {vif.r, vif.g, vif.b}, 3'b000);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/blockade_video_shifter.md
Name: blockade_video_shifter

Overview:
Pixel output stage directly downstream of the Blockade video timing/PROM stage. Takes the 8-bit character-row byte from the character PROMs (addressed by tile RAM code plus 1V/2V/4V) and serialises it MSB-first at the pixel rate. Delays hsync/vsync/hblank/vblank so they align with the serialised pixels, and drives gated r/g/b plus aligned syncs and blanks to the core video output.

Parameters:
LOAD_PHASE, 3'd7, value of h_count[2:0] at which prom_data is captured into the shifter.
SYNC_DELAY, 9, pipeline depth in ce_pix ticks applied to sync/blank inputs; must be 1..15.
INVERT, 1'b0, when 1 the serialised pixel is inverted before gating.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-low.
ce_pix  in  1  pixel clock enable, one clk wide; all state advances only when high.
h_count  in  9  horizontal counter (1H..256H), valid on ce_pix.
v_count  in  9  vertical counter (1V..256V), valid on ce_pix.
hsync_in  in  1  active-high hsync from the timing stage.
vsync_in  in  1  active-high vsync.
hblank_in  in  1  active-high hblank.
vblank_in  in  1  active-high vblank.
prom_data  in  8  character row byte; bit 7 is the leftmost pixel.
r  out  1  red.
g  out  1  green.
b  out  1  blue.
hsync  out  1  aligned hsync.
vsync  out  1  aligned vsync.
hblank  out  1  aligned hblank.
vblank  out  1  aligned vblank.
load_stb  out  1  one-clk pulse when the shifter loads; for debug/verification.

Behaviour:
- Reset is synchronous, active-low, on clk. It wins over ce_pix.
- Reset values: shifter = 0; r/g/b = 0; hsync = vsync = 0; hblank = vblank = 1; load_stb = 0. All delay-line stages: blank stages = 1, sync stages = 0.
- On ce_pix with h_count[2:0] == LOAD_PHASE: shifter <= prom_data and load_stb = 1 for that clk. Load takes priority over shift in the same tick.
- On any other ce_pix: shifter <= {shifter[6:0], 1'b0}. Pixel = shifter[7] ^ INVERT.
- Result: byte loaded at cell N's last pixel appears as pixels 0..7 on the next 8 ce_pix ticks.
- hsync/vsync/hblank/vblank: each passes through a SYNC_DELAY-deep shift line advanced on ce_pix. The output is the last stage.
- blank_any = hblank | vblank (delayed). When blank_any = 1, r = g = b = 0 regardless of pixel. Otherwise r = g = b = pixel.
- Outputs are registered and hold between ce_pix ticks. ce_pix low for any number of clks: nothing changes.
- Loads occur during blanking too; blanking masks the output only, the shifter is never cleared by blank.
- Reset asserted mid-line: next clk all outputs return to reset values. After release, the first valid pixel follows the next LOAD_PHASE tick, and syncs become valid after SYNC_DELAY ticks.
- h_count wrap (329 -> 0) needs no special handling; loads key only on h_count[2:0].

Optional Feature:
BLOCKADE_COLOR_OVERLAY_EN.
- Defined: emulates the cabinet's coloured gel overlay. When unblanked and pixel = 1, {r,g,b} = OVERLAY_LUT[v_count_d[7:5]], where v_count_d is v_count delayed by SYNC_DELAY ticks alongside the syncs. LUT default: bands 0-1 = 3'b011 (cyan), 2-5 = 3'b010 (green), 6-7 = 3'b110 (yellow).
- Undefined: monochrome white, r = g = b = pixel, and the v_count delay line is not built.

Decomposition:
- Package blockade_video_pkg holds LOAD_PHASE_DEF, SYNC_DELAY_DEF, the rgb_t 3-bit typedef and OVERLAY_LUT.
- One sub-module, blockade_delay_line (WIDTH, DEPTH, RESET_VAL, advanced by ce), instantiated for the sync/blank bundle and, with the overlay, for v_count[7:5].

Test Plan:
- Reset hold: reset = 0 for 5 clks with ce_pix toggling -> r/g/b = 0, hblank = vblank = 1, hsync = vsync = 0.
- Serialise: prom_data = 8'hA5 at h_count = 7, blanks low -> next 8 ce_pix ticks give pixels 1,0,1,0,0,1,0,1. load_stb pulses exactly once.
- Alignment: single-tick hsync_in at tick T -> hsync high at tick T + 9 only. hblank_in edge at 255 -> hblank output edge 9 ticks later.
- Blank masking: prom_data = 8'hFF with vblank_in = 1 -> r/g/b stay 0 for the whole cell. The shifter still loads (load_stb observed).
- ce_pix gaps: hold ce_pix low for 7 clks between ticks -> outputs constant during gaps and pixel sequence unchanged.
- Overlay (macro defined): pixel = 1 at v_count = 8'h20 -> rgb = 3'b011. At v_count = 8'hE0 -> 3'b110. Macro undefined -> 3'b111.
